router_sync: RTL and testbench

//  Synchronizer/control glue between the router FSM and the three output FIFOs of a 1x3 packet router.
//  - Latches the 2-bit destination address at packet start.
//  - Steers the write enable to the addressed FIFO and returns that FIFO's full flag.
//  - Drives per-port valid-out from the FIFO empty flags.
//  - Soft-resets any FIFO whose data is not read within a timeout window.

---
 rtl/router_sync_pkg.sv | 26 ++
 rtl/router_sync_timer.sv | 54 +++++
 rtl/router_sync.sv | 109 ++++++++++
 tb/tb_router_sync.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/router_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module   : router_sync_pkg
// Purpose  : Shared constants for the 1x3 router synchronizer: destination
//            address encodings, one-hot FIFO write enables and the default
//            read timeout.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package router_sync_pkg;

  localparam logic [1:0] ADDR_P0  = 2'b00;
  localparam logic [1:0] ADDR_P1  = 2'b01;
  localparam logic [1:0] ADDR_P2  = 2'b10;
  localparam logic [1:0] ADDR_INV = 2'b11;

  localparam logic [2:0] WE_NONE = 3'b000;
  localparam logic [2:0] WE_P0   = 3'b001;
  localparam logic [2:0] WE_P1   = 3'b010;
  localparam logic [2:0] WE_P2   = 3'b100;

  localparam int TIMEOUT_DEF = 30;
  localparam int CNT_W_DEF   = 5;

endpackage : router_sync_pkg
`default_nettype wire

// File: rtl/router_sync_timer.sv
`default_nettype none
// ============================================================================
// Module   : router_sync_timer
// Purpose  : Per-port read timeout. Counts consecutive cycles in which the
//            FIFO holds data that nobody reads; after TIMEOUT such cycles it
//            emits a registered one-cycle soft reset and restarts counting.
// Ports    : clock_i        - clock, rising edge
//            resetn_i       - synchronous reset, active high
//            vld_i          - FIFO holds data
//            rd_i           - FIFO is being read this cycle
//            soft_reset_o   - one-cycle timeout pulse
// Revision : 1.0 - initial release
// ============================================================================
module router_sync_timer
  import router_sync_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic clock_i,
  input  logic resetn_i,
  input  logic vld_i,
  input  logic rd_i,
  output logic soft_reset_o
);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             soft_reset_q;

  always_ff @(posedge clock_i) begin
    if (resetn_i) begin
      cnt_q        <= '0;
      soft_reset_q <= 1'b0;
    end else if (vld_i && !rd_i) begin
      // Stalled data: pulse on the TIMEOUT-th edge, then count again.
      if (cnt_q == C_CNT_LAST) begin
        cnt_q        <= '0;
        soft_reset_q <= 1'b1;
      end else begin
        cnt_q        <= cnt_q + 1'b1;
        soft_reset_q <= 1'b0;
      end
    end else begin
      cnt_q        <= '0;
      soft_reset_q <= 1'b0;
    end
  end

  assign soft_reset_o = soft_reset_q;

endmodule : router_sync_timer
`default_nettype wire

// File: rtl/router_sync.sv
`default_nettype none
// ============================================================================
// Module   : router_sync
// Purpose  : Glue between the router FSM and its three output FIFOs. Latches
//            the destination address at packet start, steers the write enable
//            and full flag, drives valid-out and soft-resets stalled FIFOs.
// Ports    : clock_i, resetn_i          - clock, sync active-high reset
//            detect_add_i, data_in_i    - header strobe and 2-bit address
//            write_enb_reg_i            - FSM write request
//            read_enb_{0,1,2}_i         - FIFO x read this cycle
//            empty_{0,1,2}_i, full_{0,1,2}_i - FIFO status
//            soft_reset_{0,1,2}_o       - registered timeout pulses
//            fifo_full_o                - full flag of addressed FIFO
//            vld_out_{0,1,2}_o          - FIFO x holds data
//            write_enb_o                - one-hot FIFO write enable
// Revision : 1.0 - initial release
// ============================================================================
module router_sync
  import router_sync_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic       clock_i,
  input  logic       resetn_i,
  input  logic       detect_add_i,
  input  logic       write_enb_reg_i,
  input  logic       read_enb_0_i,
  input  logic       read_enb_1_i,
  input  logic       read_enb_2_i,
  input  logic       empty_0_i,
  input  logic       empty_1_i,
  input  logic       empty_2_i,
  input  logic       full_0_i,
  input  logic       full_1_i,
  input  logic       full_2_i,
  input  logic [1:0] data_in_i,
  output logic       soft_reset_0_o,
  output logic       soft_reset_1_o,
  output logic       soft_reset_2_o,
  output logic       fifo_full_o,
  output logic       vld_out_0_o,
  output logic       vld_out_1_o,
  output logic       vld_out_2_o,
  output logic [2:0] write_enb_o
);

  logic [1:0] addr_q;
  logic [1:0] addr_d;
  logic [2:0] w_vld;
  logic [2:0] w_rd;
  logic [2:0] w_soft_reset;

  always_comb begin
    addr_d = detect_add_i ? data_in_i : addr_q;
  end

  always_ff @(posedge clock_i) begin
    if (resetn_i) begin
      addr_q <= ADDR_P0;
    end else begin
      addr_q <= addr_d;
    end
  end

  // Decode uses the registered address, so a header arriving together with a
  // write request still steers that write to the previous destination.
  always_comb begin
    write_enb_o = WE_NONE;
    fifo_full_o = 1'b0;
    case (addr_q)
      ADDR_P0: begin write_enb_o = WE_P0; fifo_full_o = full_0_i; end
      ADDR_P1: begin write_enb_o = WE_P1; fifo_full_o = full_1_i; end
      ADDR_P2: begin write_enb_o = WE_P2; fifo_full_o = full_2_i; end
      default: begin write_enb_o = WE_NONE; fifo_full_o = 1'b0; end
    endcase
    if (!write_enb_reg_i) begin
      write_enb_o = WE_NONE;
    end
  end

  assign w_vld = {~empty_2_i, ~empty_1_i, ~empty_0_i};
  assign w_rd  = {read_enb_2_i, read_enb_1_i, read_enb_0_i};

  assign vld_out_0_o = w_vld[0];
  assign vld_out_1_o = w_vld[1];
  assign vld_out_2_o = w_vld[2];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_timer
      router_sync_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
      ) u_timer (
        .clock_i      (clock_i),
        .resetn_i     (resetn_i),
        .vld_i        (w_vld[gi]),
        .rd_i         (w_rd[gi]),
        .soft_reset_o (w_soft_reset[gi])
      );
    end
  endgenerate

  assign soft_reset_0_o = w_soft_reset[0];
  assign soft_reset_1_o = w_soft_reset[1];
  assign soft_reset_2_o = w_soft_reset[2];

endmodule : router_sync
`default_nettype wire

// File: tb/tb_router_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_sync
// Purpose  : Directed self-checking bench for router_sync: address latch and
//            decode, full-flag mux, valid-out, per-port read timeout.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_sync;

  logic       clock;
  logic       resetn;
  logic       detect_add;
  logic       write_enb_reg;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       empty_0, empty_1, empty_2;
  logic       full_0, full_1, full_2;
  logic [1:0] data_in;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic [2:0] write_enb;

  int n_cmp;
  int n_err;

  router_sync dut (
    .clock_i         (clock),
    .resetn_i        (resetn),
    .detect_add_i    (detect_add),
    .write_enb_reg_i (write_enb_reg),
    .read_enb_0_i    (read_enb_0),
    .read_enb_1_i    (read_enb_1),
    .read_enb_2_i    (read_enb_2),
    .empty_0_i       (empty_0),
    .empty_1_i       (empty_1),
    .empty_2_i       (empty_2),
    .full_0_i        (full_0),
    .full_1_i        (full_1),
    .full_2_i        (full_2),
    .data_in_i       (data_in),
    .soft_reset_0_o  (soft_reset_0),
    .soft_reset_1_o  (soft_reset_1),
    .soft_reset_2_o  (soft_reset_2),
    .fifo_full_o     (fifo_full),
    .vld_out_0_o     (vld_out_0),
    .vld_out_1_o     (vld_out_1),
    .vld_out_2_o     (vld_out_2),
    .write_enb_o     (write_enb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %b expected %b", tag, obs, exp);
      $error("check %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    resetn = 1'b1;
    detect_add = 1'b0; write_enb_reg = 1'b0; data_in = 2'b00;
    read_enb_0 = 1'b0; read_enb_1 = 1'b0; read_enb_2 = 1'b0;
    empty_0 = 1'b1; empty_1 = 1'b1; empty_2 = 1'b1;
    full_0 = 1'b0; full_1 = 1'b0; full_2 = 1'b0;

    // Reset for two cycles
    tick(); tick();
    check("rst_soft_reset", {soft_reset_2, soft_reset_1, soft_reset_0}, 3'b000);
    check("rst_write_enb", write_enb, 3'b000);
    check("rst_fifo_full", {2'b00, fifo_full}, 3'b000);
    check("rst_vld_out", {vld_out_2, vld_out_1, vld_out_0}, 3'b000);
    resetn = 1'b0;

    // Address 10
    detect_add = 1'b1; data_in = 2'b10;
    tick();
    detect_add = 1'b0; write_enb_reg = 1'b1; #1;
    check("we_addr10", write_enb, 3'b100);
    full_2 = 1'b1; #1;
    check("ff_addr10_full2", {2'b00, fifo_full}, 3'b001);
    full_2 = 1'b0; full_0 = 1'b1; #1;
    check("ff_addr10_full0", {2'b00, fifo_full}, 3'b000);
    full_0 = 1'b0;

    // Address 00
    detect_add = 1'b1; data_in = 2'b00;
    tick();
    detect_add = 1'b0; #1;
    check("we_addr00", write_enb, 3'b001);
    full_0 = 1'b1; #1;
    check("ff_addr00_full0", {2'b00, fifo_full}, 3'b001);
    full_0 = 1'b0;

    // Address 01
    detect_add = 1'b1; data_in = 2'b01;
    tick();
    detect_add = 1'b0; #1;
    check("we_addr01", write_enb, 3'b010);
    full_1 = 1'b1; #1;
    check("ff_addr01_full1", {2'b00, fifo_full}, 3'b001);
    write_enb_reg = 1'b0; #1;
    check("ff_addr01_no_wreq", {2'b00, fifo_full}, 3'b001);
    check("we_no_wreq", write_enb, 3'b000);
    full_1 = 1'b0; write_enb_reg = 1'b1;

    // Address 11 (invalid)
    detect_add = 1'b1; data_in = 2'b11;
    tick();
    detect_add = 1'b0; #1;
    check("we_addr11", write_enb, 3'b000);
    full_0 = 1'b1; full_1 = 1'b1; full_2 = 1'b1; #1;
    check("ff_addr11_allfull", {2'b00, fifo_full}, 3'b000);
    full_0 = 1'b0; full_1 = 1'b0; full_2 = 1'b0;

    // Header and write request together: old address still steers
    detect_add = 1'b1; data_in = 2'b01; #1;
    check("we_same_cycle_old", write_enb, 3'b000);
    tick();
    detect_add = 1'b0; #1;
    check("we_same_cycle_new", write_enb, 3'b010);

    // Port 2 stalled: pulses at edge 30 and 60
    empty_2 = 1'b0; #1;
    check("vld_out_2", {vld_out_2, vld_out_1, vld_out_0}, 3'b100);
    for (int i = 1; i <= 61; i++) begin
      tick();
      if (i == 1 || i == 29 || i == 31 || i == 59 || i == 61)
        check($sformatf("sr2_low_%0d", i), {2'b00, soft_reset_2}, 3'b000);
      if (i == 30 || i == 60)
        check($sformatf("sr2_high_%0d", i), {2'b00, soft_reset_2}, 3'b001);
    end
    empty_2 = 1'b1;

    // Port 0: read at cycle 20 restarts count, pulse at edge 50
    empty_0 = 1'b0;
    for (int i = 1; i <= 51; i++) begin
      read_enb_0 = (i == 20);
      tick();
      if (i == 30 || i == 49 || i == 51)
        check($sformatf("sr0_low_%0d", i), {2'b00, soft_reset_0}, 3'b000);
      if (i == 50)
        check("sr0_high_50", {2'b00, soft_reset_0}, 3'b001);
    end
    read_enb_0 = 1'b0;

    // Empty clears the count; reset at edge 25 delays the pulse to edge 55
    empty_0 = 1'b1;
    tick();
    empty_0 = 1'b0;
    for (int i = 1; i <= 55; i++) begin
      resetn = (i == 25);
      tick();
      if (i == 25) begin
        check("sr0_during_rst", {2'b00, soft_reset_0}, 3'b000);
        check("we_addr_after_rst", write_enb, 3'b001);
      end
      if (i == 30 || i == 54)
        check($sformatf("sr0_rst_low_%0d", i), {2'b00, soft_reset_0}, 3'b000);
      if (i == 55)
        check("sr0_rst_high_55", {2'b00, soft_reset_0}, 3'b001);
    end
    resetn = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_router_sync
`default_nettype wire
